// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a data load/store port share one
// byte-addressed RAM, with round-robin arbitration and alignment checking.
module mem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     IF_REQ,
  input  logic [ADDRESS_WIDTH-1:0] IF_ADDR,
  output logic                     IF_ACK,
  output logic [DATA_WIDTH-1:0]    IF_RDATA,
  output logic                     IF_FAULT,
  input  logic                     D_REQ,
  input  logic                     D_WE,
  input  logic [1:0]               D_SIZE,
  input  logic                     D_SIGNED,
  input  logic [ADDRESS_WIDTH-1:0] D_ADDR,
  input  logic [DATA_WIDTH-1:0]    D_WDATA,
  output logic                     D_ACK,
  output logic [DATA_WIDTH-1:0]    D_RDATA,
  output logic                     D_MISALIGN,
  output logic [ADDRESS_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0]    MEM_WDATA,
  output logic                     MEM_W_EN,
  output logic [1:0]               MEM_SEL,
  input  logic [DATA_WIDTH-1:0]    MEM_RDATA
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, next_state;

  // last_data is 1 when the data port won the most recent grant
  logic last_data;
  logic gnt_data;
  logic gnt_mis;
  logic gnt_we;
  logic gnt_signed;
  logic [1:0] gnt_size;
  logic [ADDRESS_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_wdata;

  logic grant;
  logic pick_data;
  logic pick_mis;
  logic if_mis;
  logic d_mis;

  function automatic logic data_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      2'b00:   return lsb != 2'b00;
      2'b01:   return lsb[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [DATA_WIDTH-1:0] word,
                                                         input logic [1:0] size,
                                                         input logic sgn);
    case (size)
      2'b00:   return word;
      2'b01:   return {{(DATA_WIDTH-16){sgn & word[15]}}, word[15:0]};
      default: return {{(DATA_WIDTH-8){sgn & word[7]}}, word[7:0]};
    endcase
  endfunction

  assign if_mis = IF_ADDR[1:0] != 2'b00;
  assign d_mis  = data_misaligned(D_SIZE, D_ADDR[1:0]);

  always_comb begin
    next_state = state;
    grant      = 1'b0;
    pick_data  = 1'b0;
    pick_mis   = 1'b0;
    case (state)
      IDLE: begin
        if (IF_REQ || D_REQ) begin
          grant      = 1'b1;
          pick_data  = (IF_REQ && D_REQ) ? !last_data : D_REQ;
          pick_mis   = pick_data ? d_mis : if_mis;
          // a misaligned access skips the RAM entirely
          next_state = pick_mis ? DONE : ACCESS;
        end
      end
      ACCESS:  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    MEM_ADDR   = '0;
    MEM_WDATA  = '0;
    MEM_W_EN   = 1'b0;
    MEM_SEL    = 2'b00;
    IF_ACK     = 1'b0;
    IF_FAULT   = 1'b0;
    D_ACK      = 1'b0;
    D_MISALIGN = 1'b0;
    if (state == ACCESS) begin
      MEM_ADDR = gnt_addr;
      if (gnt_data) begin
        MEM_SEL   = gnt_size;
        MEM_WDATA = gnt_wdata;
        MEM_W_EN  = gnt_we && !RST;
      end
    end
    if (state == DONE) begin
      IF_ACK     = !gnt_data;
      IF_FAULT   = !gnt_data && gnt_mis;
      D_ACK      = gnt_data;
      D_MISALIGN = gnt_data && gnt_mis;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      last_data <= 1'b1;
      gnt_data  <= 1'b0;
      gnt_mis   <= 1'b0;
      IF_RDATA  <= '0;
      D_RDATA   <= '0;
    end else begin
      state <= next_state;
      if (grant) begin
        last_data <= pick_data;
        gnt_data  <= pick_data;
        gnt_mis   <= pick_mis;
      end
      if (state == ACCESS) begin
        if (!gnt_data) begin
          IF_RDATA <= MEM_RDATA;
        end else if (!gnt_we) begin
          D_RDATA <= extend_load(MEM_RDATA, gnt_size, gnt_signed);
        end
      end
    end
  end

  // transaction attributes frozen at grant time
  always_ff @(posedge CLK) begin
    if (grant) begin
      gnt_addr   <= pick_data ? D_ADDR : IF_ADDR;
      gnt_size   <= pick_data ? D_SIZE : 2'b00;
      gnt_we     <= pick_data && D_WE;
      gnt_signed <= pick_data && D_SIGNED;
      gnt_wdata  <= pick_data ? D_WDATA : '0;
    end
  end

endmodule
